// File: rtl/mppt_sequencer_if.sv
// Bundle between the control/start logic and the MPPT phase sequencer.
// Handshake: start is a level request that is accepted only while busy=0.
// Once accepted, busy stays high until the iteration ends or is aborted.
// A single-shot completion is flagged by a one-cycle done pulse.
// abort has no handshake: it is honoured on the next edge in any active state.
interface mppt_sequencer_if #(
  parameter int N_PH  = 4,
  parameter int CNT_W = 16,
  parameter int IT_W  = 8
);
  logic             start;
  logic             run_mode;
  logic             abort;
  logic [CNT_W-1:0] dwell;
  logic             rst_ci;
  logic [N_PH-1:0]  en;
  logic             busy;
  logic             done;
  logic [IT_W-1:0]  iter_cnt;

  modport master (
    output start, run_mode, abort, dwell,
    input  rst_ci, en, busy, done, iter_cnt
  );

  modport slave (
    input  start, run_mode, abort, dwell,
    output rst_ci, en, busy, done, iter_cnt
  );
endinterface

// File: rtl/mppt_sequencer.sv
// MPPT phase sequencer: ARM (counter clear), N_PH one-hot enable phases,
// then a programmable dwell before re-arming (continuous) or going idle
// (single-shot). All outputs are registered from the next-state decode so
// they line up exactly with the state being held.
module mppt_sequencer #(
  parameter int N_PH  = 4,
  parameter int CNT_W = 16,
  parameter int IT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  mppt_sequencer_if.slave     bus,
  output logic [1:0]          state_dbg
);

  localparam int PH_W = (N_PH > 1) ? $clog2(N_PH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_PHASE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [PH_W-1:0]  ph_idx, ph_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             last_phase, last_hold;
  logic             iter_inc, done_nxt;
  logic [N_PH-1:0]  en_nxt;

  logic             rst_ci_q;
  logic [N_PH-1:0]  en_q;
  logic             busy_q;
  logic             done_q;
  logic [IT_W-1:0]  iter_q;

  assign last_phase = (ph_idx == PH_W'(N_PH - 1));
  // hold_cnt counts down the remaining HOLD cycles, so 1 marks the last one.
  assign last_hold  = (hold_cnt == CNT_W'(1));

  // Next-state, counter and output-event decode; abort wins over everything.
  always_comb begin
    state_nxt = state;
    ph_nxt    = ph_idx;
    hold_nxt  = hold_cnt;
    iter_inc  = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_PHASE;
          ph_nxt    = '0;
          // A zero dwell still gives one HOLD cycle.
          hold_nxt  = (bus.dwell == '0) ? CNT_W'(1) : bus.dwell;
        end
      end
      S_PHASE: begin
        if (bus.abort)       state_nxt = S_IDLE;
        else if (last_phase) state_nxt = S_HOLD;
        else                 ph_nxt    = ph_idx + PH_W'(1);
      end
      S_HOLD: begin
        if (bus.abort) begin
          state_nxt = S_IDLE;
        end else if (last_hold) begin
          iter_inc = 1'b1;
          if (bus.run_mode) begin
            state_nxt = S_ARM;
          end else begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          hold_nxt = hold_cnt - CNT_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One-hot enable for the phase that will be active next cycle.
  always_comb begin
    en_nxt = '0;
    if (state_nxt == S_PHASE) en_nxt = N_PH'(1) << ph_nxt;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ph_idx   <= '0;
      hold_cnt <= '0;
      rst_ci_q <= 1'b0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      iter_q   <= '0;
    end else begin
      state    <= state_nxt;
      ph_idx   <= ph_nxt;
      hold_cnt <= hold_nxt;
      rst_ci_q <= (state_nxt == S_ARM);
      en_q     <= en_nxt;
      busy_q   <= (state_nxt != S_IDLE);
      done_q   <= done_nxt;
      if (iter_inc) iter_q <= iter_q + IT_W'(1);
    end
  end

  assign bus.rst_ci   = rst_ci_q;
  assign bus.en       = en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.iter_cnt = iter_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_mppt_sequencer.sv
// Bench for mppt_sequencer: a directed vector table, hand-written sequences
// for continuous mode, reset mid-HOLD and iteration wrap, then random
// stimulus. Every cycle the outputs are checked against a position-in-
// iteration reference model. A second instance with IT_W=2 shares the inputs
// to exercise counter wrap.
module tb_mppt_sequencer;

  localparam int N_PH  = 4;
  localparam int CNT_W = 16;
  localparam int IT_W  = 8;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;
  logic [1:0] state_dbg_w;

  mppt_sequencer_if #(.N_PH(N_PH), .CNT_W(CNT_W), .IT_W(IT_W)) bus ();
  mppt_sequencer_if #(.N_PH(N_PH), .CNT_W(CNT_W), .IT_W(2))    bus_w ();

  mppt_sequencer #(.N_PH(N_PH), .CNT_W(CNT_W), .IT_W(IT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  mppt_sequencer #(.N_PH(N_PH), .CNT_W(CNT_W), .IT_W(2)) dut_w (
    .clk(clk), .rst(rst), .bus(bus_w), .state_dbg(state_dbg_w)
  );

  assign bus_w.start    = bus.start;
  assign bus_w.run_mode = bus.run_mode;
  assign bus_w.abort    = bus.abort;
  assign bus_w.dwell    = bus.dwell;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // pos is the cycle number inside an iteration: 1 = counter clear,
  // 2..N_PH+1 = phases, N_PH+2..N_PH+1+D = hold.
  bit m_active;
  int m_pos;
  int m_d;
  int m_iter;
  bit m_done;

  task automatic model_step();
    if (rst) begin
      m_active = 0; m_pos = 0; m_iter = 0; m_done = 0; m_d = 1;
    end else begin
      m_done = 0;
      if (!m_active) begin
        if (bus.start && !bus.abort) begin m_active = 1; m_pos = 1; end
      end else if (bus.abort) begin
        m_active = 0; m_pos = 0;
      end else if (m_pos == 1) begin
        m_d   = (bus.dwell == 0) ? 1 : int'(bus.dwell);
        m_pos = 2;
      end else if (m_pos == N_PH + 1 + m_d) begin
        m_iter++;
        if (bus.run_mode) m_pos = 1;
        else begin m_active = 0; m_pos = 0; m_done = 1; end
      end else begin
        m_pos++;
      end
    end
  endtask

  function automatic logic [N_PH-1:0] model_en();
    logic [N_PH-1:0] e;
    e = '0;
    if (m_active && m_pos >= 2 && m_pos <= N_PH + 1) e[m_pos-2] = 1'b1;
    return e;
  endfunction

  // ---------------- driver: one clock with model check ----------------
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    chk("rst_ci",   32'(bus.rst_ci),   32'(m_active && m_pos == 1));
    chk("en",       32'(bus.en),       32'(model_en()));
    chk("busy",     32'(bus.busy),     32'(m_active));
    chk("done",     32'(bus.done),     32'(m_done));
    chk("iter_cnt", 32'(bus.iter_cnt), 32'(m_iter % 256));
    chk("iter_w",   32'(bus_w.iter_cnt), 32'(m_iter % 4));
    chk("en_onehot0",   32'($onehot0(bus.en)), 32'(1));
    chk("rst_ci_and_en", 32'(bus.rst_ci && (|bus.en)), 32'(0));
  endtask

  task automatic drive(input logic r, input logic s, input logic rm,
                       input logic ab, input logic [CNT_W-1:0] d);
    rst = r; bus.start = s; bus.run_mode = rm; bus.abort = ab; bus.dwell = d;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic             r, s, rm, ab;
    logic [CNT_W-1:0] d;
    logic             rst_ci;
    logic [N_PH-1:0]  en;
    logic             busy, done;
    logic [IT_W-1:0]  iter;
  } vec_t;

  vec_t tbl[25];

  initial begin
    bit seen_ci;

    // rst start rm abort dwell | rst_ci en busy done iter
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd3, 1'b1, 4'b0000, 1'b1, 1'b0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 4'b0001, 1'b1, 1'b0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 1'b0, 4'b0010, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 1'b0, 4'b0100, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 4'b1000, 1'b1, 1'b0, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd7, 1'b0, 4'b0000, 1'b1, 1'b0, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0, 4'b0000, 1'b1, 1'b0, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 4'b0000, 1'b1, 1'b0, 8'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 4'b0000, 1'b0, 1'b1, 8'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd1};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 4'b0000, 1'b1, 1'b0, 8'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 8'd1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 8'd1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 8'd1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd1};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 4'b0000, 1'b1, 1'b0, 8'd1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 8'd1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'b0010, 1'b1, 1'b0, 8'd1};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'b0100, 1'b1, 1'b0, 8'd1};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'b1000, 1'b1, 1'b0, 8'd1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'b0000, 1'b1, 1'b0, 8'd1};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 8'd2};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 4'b0000, 1'b0, 1'b0, 8'd2};

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0);
    m_active = 0; m_pos = 0; m_iter = 0; m_done = 0; m_d = 1;
    step();
    step();

    // ---- directed table ----
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].r, tbl[i].s, tbl[i].rm, tbl[i].ab, tbl[i].d);
      step();
      chk($sformatf("tbl%0d_rst_ci", i), 32'(bus.rst_ci),   32'(tbl[i].rst_ci));
      chk($sformatf("tbl%0d_en", i),     32'(bus.en),       32'(tbl[i].en));
      chk($sformatf("tbl%0d_busy", i),   32'(bus.busy),     32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i),   32'(bus.done),     32'(tbl[i].done));
      chk($sformatf("tbl%0d_iter", i),   32'(bus.iter_cnt), 32'(tbl[i].iter));
    end

    // ---- continuous mode, period N_PH+D+1 = 7, dwell poked mid-HOLD ----
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd2); step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'd2); step();
    chk("cont_arm1", 32'(bus.rst_ci), 32'(1));
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();          // 4 phases + first HOLD cycle
    bus.dwell = 16'd9; step();                   // second HOLD cycle
    bus.dwell = 16'd2; step();
    chk("cont_arm2", 32'(bus.rst_ci), 32'(1));
    chk("cont_iter1", 32'(bus.iter_cnt), 32'(1));
    for (int i = 0; i < 5; i++) step();          // into second HOLD
    bus.run_mode = 1'b0; step();                 // last HOLD cycle
    step();
    chk("cont_done", 32'(bus.done), 32'(1));
    chk("cont_busy", 32'(bus.busy), 32'(0));
    chk("cont_iter2", 32'(bus.iter_cnt), 32'(2));

    // ---- reset mid-HOLD in continuous mode ----
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'd4); step();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1; step();
    chk("rst_hold_busy", 32'(bus.busy), 32'(0));
    chk("rst_hold_en",   32'(bus.en),   32'(0));
    chk("rst_hold_iter", 32'(bus.iter_cnt), 32'(0));
    chk("rst_hold_state", 32'(state_dbg), 32'(0));
    rst = 1'b0;
    seen_ci = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.rst_ci) seen_ci = 1;
    end
    chk("rst_hold_no_ci", 32'(seen_ci), 32'(0));

    // ---- iteration wrap: 5 iterations, dwell 0, period 6 ----
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd0); step();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'd0); step();
    bus.start = 1'b0;
    for (int i = 0; i < 30; i++) step();
    chk("wrap_rst_ci", 32'(bus.rst_ci), 32'(1));
    chk("wrap_iter8",  32'(bus.iter_cnt), 32'(5));
    chk("wrap_iter2",  32'(bus_w.iter_cnt), 32'(1));

    // ---- randomized stimulus against the model ----
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0); step();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      bus.abort = ($urandom_range(0, 39) == 0);
      bus.start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) bus.run_mode = ~bus.run_mode;
      bus.dwell = CNT_W'($urandom_range(0, 5));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
